// File: rtl/apb2axi4_bridge_pkg.sv
// Shared types and constant AXI field encodings for the APB-to-AXI4 bridge.
package apb2axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_ACK  = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;

endpackage

// File: rtl/apb2axi4_bridge.sv
// Single-outstanding APB slave to AXI4 master bridge. Each APB access is
// turned into one single-beat INCR transaction; PREADY stays low until the
// AXI response returns, then pulses for one cycle.
// Optional: define APB2AXI_PSLVERR_EN to report non-OKAY responses on PSLVERR.
module apb2axi4_bridge
    import apb2axi_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 32,
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned LOGSIZE_BITS = 3,
    parameter int unsigned LEN_BITS     = 8,
    parameter int unsigned BURST_BITS   = 2,
    parameter int unsigned RESP_BITS    = 2,
    parameter int unsigned WSTRB_BITS   = 4
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_BITS-1:0]    PADDR,
    input  logic [DATA_BITS-1:0]    PWDATA,
    input  logic [WSTRB_BITS-1:0]   PSTRB,
    output logic                    PREADY,
    output logic [DATA_BITS-1:0]    PRDATA,
    output logic                    PSLVERR,
    output logic [ADDR_BITS-1:0]    araddr,
    output logic [LOGSIZE_BITS-1:0] arsize,
    output logic [LEN_BITS-1:0]     arlen,
    output logic [BURST_BITS-1:0]   arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_BITS-1:0]    rdata,
    input  logic [RESP_BITS-1:0]    rresp,
    input  logic                    rvalid,
    input  logic                    rlast,
    output logic                    rready,
    output logic [ADDR_BITS-1:0]    awaddr,
    output logic [LOGSIZE_BITS-1:0] awsize,
    output logic [LEN_BITS-1:0]     awlen,
    output logic [BURST_BITS-1:0]   awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_BITS-1:0]    wdata,
    output logic [WSTRB_BITS-1:0]   wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [RESP_BITS-1:0]    bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [DATA_BITS-1:0]    r_wdata;
    logic [WSTRB_BITS-1:0]   r_wstrb;
    logic [DATA_BITS-1:0]    r_prdata;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    w_setup;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_unused;

    assign w_setup = PSEL & ~PENABLE;

    assign araddr  = r_addr;
    assign awaddr  = r_addr;
    assign arsize  = LOGSIZE_BITS'(AXI_SIZE_4B);
    assign awsize  = LOGSIZE_BITS'(AXI_SIZE_4B);
    assign arlen   = LEN_BITS'(AXI_LEN_SINGLE);
    assign awlen   = LEN_BITS'(AXI_LEN_SINGLE);
    assign arburst = BURST_BITS'(AXI_BURST_INCR);
    assign awburst = BURST_BITS'(AXI_BURST_INCR);
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = wvalid;
    assign PRDATA  = r_prdata;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode and channel handshake outputs.
    always_comb begin
        w_next  = r_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        PREADY  = 1'b0;
        w_aw_hs = 1'b0;
        w_w_hs  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_setup) w_next = PWRITE ? ST_AW_W : ST_AR;
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) w_next = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid) w_next = ST_ACK;
            end
            ST_AW_W: begin
                // Each valid falls once its own handshake is recorded; B waits for both.
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                w_aw_hs = awvalid & awready;
                w_w_hs  = wvalid & wready;
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_next = ST_B;
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) w_next = ST_ACK;
            end
            ST_ACK: begin
                PREADY = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture, AW/W completion tracking and read data latch.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_prdata  <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (w_setup) begin
                    r_addr  <= PADDR;
                    r_wdata <= PWDATA;
                    r_wstrb <= PSTRB;
                end
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (r_state == ST_R && rvalid) r_prdata <= rdata;
        end
    end

`ifdef APB2AXI_PSLVERR_EN
    logic [RESP_BITS-1:0] r_resp;

    // Response code of the last completed read or write.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                       r_resp <= '0;
        else if (r_state == ST_R && rvalid) r_resp <= rresp;
        else if (r_state == ST_B && bvalid) r_resp <= bresp;
    end

    assign PSLVERR  = (r_state == ST_ACK) && (r_resp != RESP_BITS'(AXI_RESP_OKAY));
    assign w_unused = rlast;
`else
    assign PSLVERR  = 1'b0;
    assign w_unused = &{1'b0, rlast, rresp, bresp};
`endif

endmodule

// File: tb/tb_apb2axi4_bridge.sv
// Self-checking bench for apb2axi4_bridge: APB master driver, AXI slave memory
// with programmable wait states, and a word-level reference memory.
module tb_apb2axi4_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rlast, rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    apb2axi4_bridge #(.ADDR_BITS(32), .DATA_BITS(32)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    // Slave wait states (cycles of valid/ready before the response side acts).
    int d_ar, d_r, d_aw, d_w, d_b;
    logic [1:0] s_rresp, s_bresp;

    // Expected request fields for the transaction in flight.
    logic [31:0] exp_addr, exp_wdata, exp_prd;
    logic [3:0]  exp_strb;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] smem    [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic exp_err(input logic [1:0] resp);
`ifdef APB2AXI_PSLVERR_EN
        return resp != 2'b00;
`else
        return 1'b0 & resp[0];
`endif
    endfunction

    // AXI slave memory, reacting on the falling edge.
    initial begin : slave
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        bit rd_pend, aw_got, w_got;
        logic [31:0] cap_rd_addr, cap_awaddr, cap_wdata, v;
        logic [3:0]  cap_wstrb;
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_pend = 0; aw_got = 0; w_got = 0;
        cap_rd_addr = '0; cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                rd_pend = 0; aw_got = 0; w_got = 0;
                continue;
            end
            // AR
            if (arready) begin
                chk("ar_drop", arvalid, 1'b0);
                arready = 0;
            end else if (arvalid) begin
                ar_cnt++;
                if (ar_cnt > d_ar) begin
                    chk("araddr", araddr, exp_addr);
                    chk("ar_fields", {arlen, arsize, arburst}, {8'h00, 3'b010, 2'b01});
                    arready = 1; rd_pend = 1; r_cnt = 0; ar_cnt = 0;
                    cap_rd_addr = araddr;
                end
            end
            // R
            if (rvalid) begin
                rvalid = 0; rlast = 0;
            end else if (rd_pend && rready) begin
                if (r_cnt >= d_r) begin
                    rvalid = 1; rlast = 1; rresp = s_rresp; rd_pend = 0;
                    rdata = smem.exists(cap_rd_addr) ? smem[cap_rd_addr] : 32'h0;
                end else r_cnt++;
            end
            // AW
            if (awready) begin
                chk("aw_drop", awvalid, 1'b0);
                awready = 0;
            end else if (awvalid) begin
                aw_cnt++;
                if (aw_cnt > d_aw) begin
                    chk("aw_dup", aw_got, 1'b0);
                    chk("awaddr", awaddr, exp_addr);
                    chk("aw_fields", {awlen, awsize, awburst}, {8'h00, 3'b010, 2'b01});
                    awready = 1; aw_got = 1; aw_cnt = 0; cap_awaddr = awaddr;
                end
            end
            // W
            if (wready) begin
                chk("w_drop", wvalid, 1'b0);
                wready = 0;
            end else if (wvalid) begin
                w_cnt++;
                if (w_cnt > d_w) begin
                    chk("w_dup", w_got, 1'b0);
                    chk("wdata", wdata, exp_wdata);
                    chk("wstrb", wstrb, exp_strb);
                    chk("wlast", wlast, 1'b1);
                    wready = 1; w_got = 1; w_cnt = 0;
                    cap_wdata = wdata; cap_wstrb = wstrb;
                end
            end
            // B
            if (bvalid) begin
                bvalid = 0;
            end else if (bready) begin
                chk("b_order", {aw_got, w_got}, 2'b11);
                if (b_cnt >= d_b) begin
                    v = smem.exists(cap_awaddr) ? smem[cap_awaddr] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (cap_wstrb[i]) v[i*8 +: 8] = cap_wdata[i*8 +: 8];
                    smem[cap_awaddr] = v;
                    bvalid = 1; bresp = s_bresp; b_cnt = 0; aw_got = 0; w_got = 0;
                end else b_cnt++;
            end
        end
    end

    // One complete APB access, checked against the reference model.
    task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n, exp_n;
        bit got;
        logic [31:0] mask;
        exp_addr = a; exp_wdata = d; exp_strb = s;
        exp_n = wr ? 3 + ((d_aw > d_w) ? d_aw : d_w) + d_b : 3 + d_ar + d_r;
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(negedge PCLK);
            n++;
            PENABLE = 1;
            if (PREADY) got = 1;
        end
        chk("pready_seen", got, 1'b1);
        chk("latency", n, exp_n);
        if (!wr) exp_prd = ref_rd(a);
        chk("prdata", PRDATA, exp_prd);
        chk("pslverr_ack", PSLVERR, exp_err(wr ? s_bresp : s_rresp));
        PSEL = 0; PENABLE = 0;
        @(negedge PCLK);
        chk("pready_pulse", PREADY, 1'b0);
        chk("pslverr_idle", PSLVERR, 1'b0);
        if (wr) begin
            mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            ref_mem[a] = (ref_rd(a) & ~mask) | (d & mask);
        end
    endtask

    initial begin : main
        logic [31:0] a;
        PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        d_ar = 0; d_r = 0; d_aw = 0; d_w = 0; d_b = 0;
        s_rresp = 2'b00; s_bresp = 2'b00;
        exp_addr = '0; exp_wdata = '0; exp_strb = '0; exp_prd = '0;
        repeat (2) @(negedge PCLK);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        PRESETn = 1;

        // Basic write then readback.
        apb_xfer(1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
        apb_xfer(0, 32'h1000_0010, 32'h0, 4'h0);
        chk("rd_deadbeef", PRDATA, 32'hDEAD_BEEF);

        // AW stalled 3 cycles, W accepted immediately.
        d_aw = 3;
        apb_xfer(1, 32'h1000_0020, 32'h0BAD_F00D, 4'hF);
        d_aw = 0;

        // Byte-lane merge.
        apb_xfer(1, 32'h1000_0030, 32'h1122_3344, 4'hF);
        apb_xfer(1, 32'h1000_0030, 32'h0000_AB00, 4'b0010);
        apb_xfer(0, 32'h1000_0030, 32'h0, 4'h0);
        chk("rd_partial", PRDATA, 32'h1122_AB44);

        // Error responses on both channels.
        s_bresp = 2'b10;
        apb_xfer(1, 32'h1000_0040, 32'h5555_AAAA, 4'hF);
        s_bresp = 2'b00; s_rresp = 2'b11;
        apb_xfer(0, 32'h1000_0040, 32'h0, 4'h0);
        s_rresp = 2'b00;

        // Reset while AR is stalled.
        d_ar = 1000;
        exp_addr = 32'h1000_0010;
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h1000_0010;
        @(negedge PCLK);
        PENABLE = 1;
        repeat (2) @(negedge PCLK);
        chk("ar_stalled", arvalid, 1'b1);
        PRESETn = 0; PSEL = 0; PENABLE = 0;
        #1;
        chk("abort_arvalid", arvalid, 1'b0);
        chk("abort_pready", PREADY, 1'b0);
        chk("abort_prdata", PRDATA, 32'h0);
        exp_prd = 32'h0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1;
        d_ar = 0;
        apb_xfer(0, 32'h1000_0010, 32'h0, 4'h0);

        // Random traffic with random wait states and responses.
        for (int t = 0; t < 40; t++) begin
            d_ar = $urandom_range(0, 3); d_r = $urandom_range(0, 3);
            d_aw = $urandom_range(0, 3); d_w = $urandom_range(0, 3);
            d_b  = $urandom_range(0, 3);
            s_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            s_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            a = 32'h1000_0000 + 32'($urandom_range(0, 3)) * 4;
            apb_xfer($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
